// File: rtl/rps_match_engine.sv
// Rock-paper-scissors round and match controller: takes a user play, waits for a
// strategy choice with timeout, judges the round and keeps saturating scores.

module rps_match_engine_chk (
    input logic clk,
    input logic rst,
    input logic uwin,
    input logic cwin,
    input logic draw,
    input logic commit
);
    a_flags_onehot0: assert property (@(posedge clk) disable iff (rst) $onehot0({uwin, cwin, draw}));
    a_commit_verdict: assert property (@(posedge clk) disable iff (rst) commit |-> $onehot({uwin, cwin, draw}));
endmodule

module rps_match_engine #(
    parameter int SCORE_W      = 8,
    parameter int ROUND_W      = 8,
    parameter int MATCH_POINTS = 0,
    parameter int COM_TIMEOUT  = 1024
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic               play,
    input  logic               new_match,
    input  logic [1:0]         user_choice,
    input  logic [1:0]         com_choice,
    input  logic               com_ready,
    output logic [1:0]         com_loaded,
    output logic [1:0]         user_q,
    output logic               uwin,
    output logic               cwin,
    output logic               draw,
    output logic [SCORE_W-1:0] user_score,
    output logic [SCORE_W-1:0] com_score,
    output logic [SCORE_W-1:0] draw_count,
    output logic [ROUND_W-1:0] round_count,
    output logic               commit,
    output logic               busy,
    output logic               timeout,
    output logic               invalid,
    output logic               match_over,
    output logic               match_winner
);
    localparam int                 TO_W       = $clog2(COM_TIMEOUT);
    localparam logic [TO_W-1:0]    TO_LAST    = TO_W'(COM_TIMEOUT - 1);
    localparam logic [SCORE_W-1:0] SCORE_MAX  = {SCORE_W{1'b1}};
    localparam logic [31:0]        MATCH_PTS  = 32'(MATCH_POINTS);
    localparam logic [1:0]         ROCK       = 2'b00;
    localparam logic [1:0]         SCISSOR    = 2'b01;
    localparam logic [1:0]         PAPER      = 2'b10;
    localparam logic [1:0]         CHOICE_BAD = 2'b11;
    localparam logic [1:0]         RES_DRAW   = 2'b00;
    localparam logic [1:0]         RES_UWIN   = 2'b01;
    localparam logic [1:0]         RES_CWIN   = 2'b10;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_WAIT_COM = 2'd1,
        ST_JUDGE    = 2'd2,
        ST_OVER     = 2'd3
    } state_t;

    state_t             state_r;
    logic [TO_W-1:0]    wait_cnt_r;
    logic [1:0]         user_lat_r;
    logic [1:0]         com_loaded_r;
    logic [1:0]         user_q_r;
    logic               uwin_r, cwin_r, draw_r;
    logic [SCORE_W-1:0] user_score_r, com_score_r, draw_count_r;
    logic [ROUND_W-1:0] round_count_r;
    logic               commit_r, busy_r, timeout_r, invalid_r;
    logic               match_over_r, match_winner_r;

    logic [1:0]         result_s;
    logic [SCORE_W-1:0] user_score_nx_s, com_score_nx_s, draw_count_nx_s;
    logic               accept_s, user_hit_s, com_hit_s;

    function automatic logic [1:0] judge_round(input logic [1:0] u, input logic [1:0] c);
        logic [1:0] res;
        if (u == c) begin
            res = RES_DRAW;
        end else if ((u == ROCK && c == SCISSOR) || (u == SCISSOR && c == PAPER) ||
                     (u == PAPER && c == ROCK)) begin
            res = RES_UWIN;
        end else begin
            res = RES_CWIN;
        end
        return res;
    endfunction

    function automatic logic [SCORE_W-1:0] sat_inc(input logic [SCORE_W-1:0] v);
        logic [SCORE_W-1:0] r;
        if (v == SCORE_MAX) begin
            r = v;
        end else begin
            r = v + SCORE_W'(1);
        end
        return r;
    endfunction

    // Round verdict and post-round scores from the latched choices only.
    always_comb begin
        result_s        = judge_round(user_lat_r, com_loaded_r);
        user_score_nx_s = user_score_r;
        com_score_nx_s  = com_score_r;
        draw_count_nx_s = draw_count_r;
        case (result_s)
            RES_UWIN: user_score_nx_s = sat_inc(user_score_r);
            RES_CWIN: com_score_nx_s  = sat_inc(com_score_r);
            RES_DRAW: draw_count_nx_s = sat_inc(draw_count_r);
            default:  draw_count_nx_s = draw_count_r;
        endcase
        accept_s   = com_ready && (com_choice != CHOICE_BAD);
        user_hit_s = (MATCH_PTS != 32'd0) && (32'(user_score_nx_s) == MATCH_PTS);
        com_hit_s  = (MATCH_PTS != 32'd0) && (32'(com_score_nx_s) == MATCH_PTS);
    end

    // Round/match state machine with all outputs registered alongside the state.
    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            state_r        <= ST_IDLE;
            wait_cnt_r     <= '0;
            user_lat_r     <= 2'b00;
            com_loaded_r   <= 2'b00;
            user_q_r       <= 2'b00;
            uwin_r         <= 1'b0;
            cwin_r         <= 1'b0;
            draw_r         <= 1'b0;
            user_score_r   <= '0;
            com_score_r    <= '0;
            draw_count_r   <= '0;
            round_count_r  <= '0;
            commit_r       <= 1'b0;
            busy_r         <= 1'b0;
            timeout_r      <= 1'b0;
            invalid_r      <= 1'b0;
            match_over_r   <= 1'b0;
            match_winner_r <= 1'b0;
        end else begin
            commit_r  <= 1'b0;
            timeout_r <= 1'b0;
            invalid_r <= 1'b0;
            if (new_match) begin
                state_r        <= ST_IDLE;
                wait_cnt_r     <= '0;
                user_lat_r     <= 2'b00;
                com_loaded_r   <= 2'b00;
                user_q_r       <= 2'b00;
                uwin_r         <= 1'b0;
                cwin_r         <= 1'b0;
                draw_r         <= 1'b0;
                user_score_r   <= '0;
                com_score_r    <= '0;
                draw_count_r   <= '0;
                round_count_r  <= '0;
                busy_r         <= 1'b0;
                match_over_r   <= 1'b0;
                match_winner_r <= 1'b0;
            end else begin
                case (state_r)
                    ST_IDLE: begin
                        if (play) begin
                            if (user_choice == CHOICE_BAD) begin
                                invalid_r <= 1'b1;
                            end else begin
                                user_lat_r <= user_choice;
                                uwin_r     <= 1'b0;
                                cwin_r     <= 1'b0;
                                draw_r     <= 1'b0;
                                wait_cnt_r <= '0;
                                busy_r     <= 1'b1;
                                state_r    <= ST_WAIT_COM;
                            end
                        end
                    end
                    ST_WAIT_COM: begin
                        // A valid choice on the last allowed cycle still wins over the timeout.
                        if (accept_s) begin
                            com_loaded_r <= com_choice;
                            state_r      <= ST_JUDGE;
                        end else if (wait_cnt_r == TO_LAST) begin
                            timeout_r <= 1'b1;
                            busy_r    <= 1'b0;
                            state_r   <= ST_IDLE;
                        end else begin
                            wait_cnt_r <= wait_cnt_r + TO_W'(1);
                        end
                    end
                    ST_JUDGE: begin
                        uwin_r        <= (result_s == RES_UWIN);
                        cwin_r        <= (result_s == RES_CWIN);
                        draw_r        <= (result_s == RES_DRAW);
                        user_score_r  <= user_score_nx_s;
                        com_score_r   <= com_score_nx_s;
                        draw_count_r  <= draw_count_nx_s;
                        round_count_r <= round_count_r + ROUND_W'(1);
                        user_q_r      <= user_lat_r;
                        commit_r      <= 1'b1;
                        busy_r        <= 1'b0;
                        if (user_hit_s || com_hit_s) begin
                            match_over_r   <= 1'b1;
                            match_winner_r <= user_hit_s;
                            state_r        <= ST_OVER;
                        end else begin
                            state_r <= ST_IDLE;
                        end
                    end
                    ST_OVER: begin
                        state_r <= ST_OVER;
                    end
                    default: begin
                        busy_r  <= 1'b0;
                        state_r <= ST_IDLE;
                    end
                endcase
            end
        end
    end

    assign com_loaded   = com_loaded_r;
    assign user_q       = user_q_r;
    assign uwin         = uwin_r;
    assign cwin         = cwin_r;
    assign draw         = draw_r;
    assign user_score   = user_score_r;
    assign com_score    = com_score_r;
    assign draw_count   = draw_count_r;
    assign round_count  = round_count_r;
    assign commit       = commit_r;
    assign busy         = busy_r;
    assign timeout      = timeout_r;
    assign invalid      = invalid_r;
    assign match_over   = match_over_r;
    assign match_winner = match_winner_r;

    rps_match_engine_chk u_chk (
        .clk    (CLOCK_50),
        .rst    (reset),
        .uwin   (uwin_r),
        .cwin   (cwin_r),
        .draw   (draw_r),
        .commit (commit_r)
    );
endmodule

// File: tb/tb_rps_match_engine.sv
// Two differently parameterised engines share one stimulus stream and are checked
// every cycle against a behavioural model of the round/match rules.

module tb_rps_match_engine;
    logic       CLOCK_50 = 1'b0;
    logic       reset, play, new_match, com_ready;
    logic [1:0] user_choice, com_choice;

    always #5 CLOCK_50 = ~CLOCK_50;

    // instance 0: SCORE_W=2, ROUND_W=2, unlimited, timeout 8
    logic [1:0] d0_cl, d0_uq, d0_us, d0_cs, d0_dc, d0_rc;
    logic       d0_uwin, d0_cwin, d0_draw, d0_commit, d0_busy, d0_to, d0_inv, d0_over, d0_win;
    // instance 1: SCORE_W=4, ROUND_W=4, first to 3, timeout 5
    logic [1:0] d1_cl, d1_uq;
    logic [3:0] d1_us, d1_cs, d1_dc, d1_rc;
    logic       d1_uwin, d1_cwin, d1_draw, d1_commit, d1_busy, d1_to, d1_inv, d1_over, d1_win;

    rps_match_engine #(.SCORE_W(2), .ROUND_W(2), .MATCH_POINTS(0), .COM_TIMEOUT(8)) dut0 (
        .CLOCK_50(CLOCK_50), .reset(reset), .play(play), .new_match(new_match),
        .user_choice(user_choice), .com_choice(com_choice), .com_ready(com_ready),
        .com_loaded(d0_cl), .user_q(d0_uq), .uwin(d0_uwin), .cwin(d0_cwin), .draw(d0_draw),
        .user_score(d0_us), .com_score(d0_cs), .draw_count(d0_dc), .round_count(d0_rc),
        .commit(d0_commit), .busy(d0_busy), .timeout(d0_to), .invalid(d0_inv),
        .match_over(d0_over), .match_winner(d0_win));

    rps_match_engine #(.SCORE_W(4), .ROUND_W(4), .MATCH_POINTS(3), .COM_TIMEOUT(5)) dut1 (
        .CLOCK_50(CLOCK_50), .reset(reset), .play(play), .new_match(new_match),
        .user_choice(user_choice), .com_choice(com_choice), .com_ready(com_ready),
        .com_loaded(d1_cl), .user_q(d1_uq), .uwin(d1_uwin), .cwin(d1_cwin), .draw(d1_draw),
        .user_score(d1_us), .com_score(d1_cs), .draw_count(d1_dc), .round_count(d1_rc),
        .commit(d1_commit), .busy(d1_busy), .timeout(d1_to), .invalid(d1_inv),
        .match_over(d1_over), .match_winner(d1_win));

    localparam int SMAX[2] = '{3, 15};
    localparam int RMOD[2] = '{4, 16};
    localparam int MPT[2]  = '{0, 3};
    localparam int TOT[2]  = '{8, 5};

    int checks = 0;
    int errors = 0;

    // model: mode 0 waiting for play, 1 waiting for computer, 2 judging, 3 match finished
    int m_mode[2], m_wcnt[2], m_ulat[2], m_cl[2], m_uq[2];
    int m_uwin[2], m_cwin[2], m_draw[2], m_us[2], m_cs[2], m_dc[2], m_rc[2];
    int m_commit[2], m_busy[2], m_to[2], m_inv[2], m_over[2], m_win[2];

    task automatic chk(string name, int i, int act, int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s inst%0d t=%0t got %0d expected %0d", name, i, $time, act, exp);
        end
    endtask

    task automatic model_clear(int i);
        m_mode[i] = 0; m_wcnt[i] = 0; m_ulat[i] = 0; m_cl[i] = 0; m_uq[i] = 0;
        m_uwin[i] = 0; m_cwin[i] = 0; m_draw[i] = 0;
        m_us[i] = 0; m_cs[i] = 0; m_dc[i] = 0; m_rc[i] = 0;
        m_commit[i] = 0; m_busy[i] = 0; m_to[i] = 0; m_inv[i] = 0; m_over[i] = 0; m_win[i] = 0;
    endtask

    task automatic model_step(int i);
        int u, c;
        m_commit[i] = 0; m_to[i] = 0; m_inv[i] = 0;
        if (new_match) begin
            model_clear(i);
        end else if (m_mode[i] == 0) begin
            if (play) begin
                if (user_choice == 2'd3) begin
                    m_inv[i] = 1;
                end else begin
                    m_ulat[i] = user_choice;
                    m_uwin[i] = 0; m_cwin[i] = 0; m_draw[i] = 0;
                    m_wcnt[i] = 0;
                    m_mode[i] = 1;
                end
            end
        end else if (m_mode[i] == 1) begin
            m_wcnt[i]++;
            if (com_ready && com_choice != 2'd3) begin
                m_cl[i] = com_choice;
                m_mode[i] = 2;
            end else if (m_wcnt[i] == TOT[i]) begin
                m_to[i] = 1;
                m_mode[i] = 0;
            end
        end else if (m_mode[i] == 2) begin
            u = m_ulat[i];
            c = m_cl[i];
            m_uwin[i] = ((u + 1) % 3 == c) ? 1 : 0;
            m_cwin[i] = ((c + 1) % 3 == u) ? 1 : 0;
            m_draw[i] = (u == c) ? 1 : 0;
            if (m_uwin[i] == 1 && m_us[i] < SMAX[i]) m_us[i]++;
            if (m_cwin[i] == 1 && m_cs[i] < SMAX[i]) m_cs[i]++;
            if (m_draw[i] == 1 && m_dc[i] < SMAX[i]) m_dc[i]++;
            m_rc[i] = (m_rc[i] + 1) % RMOD[i];
            m_commit[i] = 1;
            m_uq[i] = u;
            if (MPT[i] != 0 && (m_us[i] == MPT[i] || m_cs[i] == MPT[i])) begin
                m_mode[i] = 3;
                m_win[i] = (m_us[i] == MPT[i]) ? 1 : 0;
            end else begin
                m_mode[i] = 0;
            end
        end
        m_busy[i] = (m_mode[i] == 1 || m_mode[i] == 2) ? 1 : 0;
        m_over[i] = (m_mode[i] == 3) ? 1 : 0;
    endtask

    initial begin
        model_clear(0);
        model_clear(1);
        forever begin
            @(posedge CLOCK_50 or posedge reset);
            for (int i = 0; i < 2; i++) begin
                if (reset) model_clear(i);
                else model_step(i);
            end
        end
    end

    task automatic cmp_inst(int i, int cl, int uq, int uw, int cw, int dr, int us, int cs, int dc,
                            int rc, int cm, int bz, int tmo, int inv, int ov, int mw);
        chk("com_loaded", i, cl, m_cl[i]);
        chk("user_q", i, uq, m_uq[i]);
        chk("uwin", i, uw, m_uwin[i]);
        chk("cwin", i, cw, m_cwin[i]);
        chk("draw", i, dr, m_draw[i]);
        chk("user_score", i, us, m_us[i]);
        chk("com_score", i, cs, m_cs[i]);
        chk("draw_count", i, dc, m_dc[i]);
        chk("round_count", i, rc, m_rc[i]);
        chk("commit", i, cm, m_commit[i]);
        chk("busy", i, bz, m_busy[i]);
        chk("timeout", i, tmo, m_to[i]);
        chk("invalid", i, inv, m_inv[i]);
        chk("match_over", i, ov, m_over[i]);
        chk("match_winner", i, mw, m_win[i]);
    endtask

    initial begin
        forever begin
            @(negedge CLOCK_50);
            cmp_inst(0, d0_cl, d0_uq, d0_uwin, d0_cwin, d0_draw, d0_us, d0_cs, d0_dc, d0_rc,
                     d0_commit, d0_busy, d0_to, d0_inv, d0_over, d0_win);
            cmp_inst(1, d1_cl, d1_uq, d1_uwin, d1_cwin, d1_draw, d1_us, d1_cs, d1_dc, d1_rc,
                     d1_commit, d1_busy, d1_to, d1_inv, d1_over, d1_win);
        end
    end

    task automatic tick(int n);
        repeat (n) begin
            @(posedge CLOCK_50);
            #2;
        end
    endtask

    task automatic pulse_play(logic [1:0] u);
        user_choice = u;
        play = 1'b1;
        tick(1);
        play = 1'b0;
    endtask

    task automatic pulse_nm();
        new_match = 1'b1;
        tick(1);
        new_match = 1'b0;
    endtask

    // play at edge N, computer ready at N+1, verdict visible after N+2
    task automatic do_round(logic [1:0] u, logic [1:0] c);
        com_ready = 1'b1;
        com_choice = c;
        pulse_play(u);
        tick(2);
    endtask

    initial begin
        int pr;
        int r;
        reset = 1'b1; play = 1'b0; new_match = 1'b0; com_ready = 1'b0;
        user_choice = 2'd0; com_choice = 2'd0;
        tick(3);
        reset = 1'b0;
        tick(1);
        chk("lit_reset_score", 0, d0_us, 0);
        chk("lit_reset_busy", 0, d0_busy, 0);

        do_round(2'd0, 2'd1);
        chk("lit_first_commit", 0, d0_commit, 1);
        chk("lit_first_uwin", 0, d0_uwin, 1);
        chk("lit_first_score", 0, d0_us, 1);
        chk("lit_first_round", 0, d0_rc, 1);
        chk("lit_first_com_loaded", 0, d0_cl, 1);
        chk("lit_model_score", 0, m_us[0], 1);
        tick(1);
        chk("lit_commit_once", 0, d0_commit, 0);

        pulse_nm();
        for (int u = 0; u < 3; u++)
            for (int c = 0; c < 3; c++)
                do_round(2'(u), 2'(c));
        chk("lit_pairs_user", 0, d0_us, 3);
        chk("lit_pairs_com", 0, d0_cs, 3);
        chk("lit_pairs_draw", 0, d0_dc, 3);
        chk("lit_pairs_round_wrap", 0, d0_rc, 1);
        chk("lit_pairs_over", 1, d1_over, 1);
        chk("lit_pairs_winner", 1, d1_win, 1);
        chk("lit_pairs_round_frozen", 1, d1_rc, 7);
        chk("lit_model_over", 1, m_over[1], 1);

        pulse_nm();
        chk("lit_nm_over", 1, d1_over, 0);
        chk("lit_nm_score", 1, d1_us, 0);
        com_ready = 1'b0;
        pulse_play(2'd0);
        tick(4);
        chk("lit_to_early", 1, d1_to, 0);
        tick(1);
        chk("lit_to_pulse", 1, d1_to, 1);
        chk("lit_to_idle", 1, d1_busy, 0);
        tick(2);
        chk("lit_to_wait", 0, d0_busy, 1);
        chk("lit_to_early", 0, d0_to, 0);
        tick(1);
        chk("lit_to_pulse", 0, d0_to, 1);
        chk("lit_to_idle", 0, d0_busy, 0);
        chk("lit_to_scores", 0, d0_us + d0_cs + d0_dc, 0);
        do_round(2'd1, 2'd2);
        chk("lit_after_to_uwin", 0, d0_uwin, 1);

        pulse_play(2'd3);
        chk("lit_invalid", 0, d0_inv, 1);
        chk("lit_invalid_busy", 0, d0_busy, 0);
        tick(1);
        chk("lit_invalid_once", 0, d0_inv, 0);

        com_ready = 1'b1;
        com_choice = 2'd3;
        pulse_play(2'd2);
        tick(3);
        chk("lit_bad_com_wait", 0, d0_busy, 1);
        com_choice = 2'd0;
        tick(2);
        chk("lit_good_com_commit", 0, d0_commit, 1);
        chk("lit_good_com_uwin", 0, d0_uwin, 1);
        chk("lit_good_com_uq", 0, d0_uq, 2);

        pulse_nm();
        repeat (5) do_round(2'd0, 2'd1);
        chk("lit_sat_score", 0, d0_us, 3);
        chk("lit_sat_round", 0, d0_rc, 1);

        pulse_nm();
        repeat (3) do_round(2'd0, 2'd2);
        chk("lit_cpu_over", 1, d1_over, 1);
        chk("lit_cpu_winner", 1, d1_win, 0);
        chk("lit_cpu_score", 1, d1_cs, 3);
        do_round(2'd0, 2'd1);
        chk("lit_over_ignores_play", 1, d1_us, 0);
        chk("lit_over_round", 1, d1_rc, 3);
        pulse_nm();
        chk("lit_cpu_nm_over", 1, d1_over, 0);
        chk("lit_cpu_nm_round", 1, d1_rc, 0);

        com_ready = 1'b0;
        pulse_play(2'd0);
        tick(2);
        pulse_nm();
        chk("lit_abort_busy", 0, d0_busy, 0);
        new_match = 1'b1;
        play = 1'b1;
        tick(1);
        new_match = 1'b0;
        play = 1'b0;
        chk("lit_nm_drops_play", 0, d0_busy, 0);
        pulse_play(2'd0);
        tick(2);
        reset = 1'b1;
        #1;
        chk("lit_async_reset", 0, d0_busy, 0);
        tick(1);
        reset = 1'b0;
        tick(1);

        for (int k = 0; k < 15; k++) begin
            pr = (k % 3 == 0) ? 10 : 55;
            repeat (200) begin
                r = $urandom_range(0, 999);
                reset = (r < 3);
                new_match = (r >= 3 && r < 20);
                play = ($urandom_range(0, 99) < 35);
                user_choice = 2'($urandom_range(0, 3));
                com_ready = ($urandom_range(0, 99) < pr);
                com_choice = 2'($urandom_range(0, 3));
                tick(1);
            end
        end
        reset = 1'b0; new_match = 1'b0; play = 1'b0; com_ready = 1'b0;
        tick(3);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/rps_match_engine.md
Name: rps_match_engine

Overview:
Synchronous rock-paper-scissors round and match controller. It replaces the key-edge-clocked scoring logic in the game top. It accepts a user choice, waits on a selected strategy (random, markov, reinforce) via a ready handshake with timeout, judges the round against the freshly latched computer choice, and keeps saturating scores. It also enforces an optional first-to-N match limit and pulses a commit strobe so learning strategies can update.

Parameters:
SCORE_W, 8, width of user_score/com_score/draw_count; scores saturate at 2^SCORE_W-1
ROUND_W, 8, width of round_count; wraps modulo 2^ROUND_W
MATCH_POINTS, 0, score that ends the match; 0 = unlimited play
COM_TIMEOUT, 1024, max cycles spent in WAIT_COM before the round is aborted (>=2)

Ports:
CLOCK_50  in  1  system clock
reset  in  1  asynchronous, active-high; clears all state
play  in  1  one-cycle request pulse (debounced/synchronised upstream)
new_match  in  1  one-cycle pulse; clears scores and counts, returns to IDLE
user_choice  in  2  00 rock, 01 scissor, 10 paper, 11 invalid
com_choice  in  2  selected strategy output, same encoding
com_ready  in  1  strategy choice valid this cycle
com_loaded  out  2  computer choice used in last judged round
user_q  out  2  user choice used in last judged round
uwin, cwin, draw  out  1 each  result of last judged round; one-hot or all zero
user_score, com_score, draw_count  out  SCORE_W each
round_count  out  ROUND_W  judged rounds since reset/new_match
commit  out  1  one-cycle pulse; user_q/com_loaded valid for strategy learning
busy  out  1  high in WAIT_COM and JUDGE
timeout  out  1  one-cycle pulse on WAIT_COM abort
invalid  out  1  one-cycle pulse when play seen with user_choice=11
match_over  out  1  high in OVER state
match_winner  out  1  1 = user reached MATCH_POINTS, 0 = computer; valid when match_over

Behaviour:
- Reset (async, active-high): all outputs 0, state IDLE, timeout counter 0.
- All outputs are registered. No combinational path from inputs to outputs.
- Priority every cycle: reset > new_match > state logic.
- new_match, any state: scores, draw_count, round_count, flags, com_loaded and user_q go to 0; state goes to IDLE.
  - An in-flight round is aborted with no commit.
  - A play in the same cycle is dropped.
- IDLE:
  - play with user_choice=11: invalid pulses, state stays IDLE.
  - play with a valid choice: latch user choice, clear uwin/cwin/draw, counter=0, go to WAIT_COM.
- WAIT_COM:
  - com_ready=1 and com_choice!=11: latch com_loaded, go to JUDGE.
  - com_ready with com_choice=11 is ignored.
  - Counter increments each cycle. If it reaches COM_TIMEOUT-1 without acceptance: timeout pulse, go to IDLE, scores unchanged.
  - play while busy is ignored; there is no queuing.
- JUDGE (exactly one cycle), using the latched values only:
  - rock beats scissor, scissor beats paper, paper beats rock; equal choices = draw.
  - Set exactly one of uwin/cwin/draw.
  - Increment the matching counter, saturating at max.
  - round_count+1, wrapping.
  - commit pulses and user_q updates.
  - Next state: if MATCH_POINTS!=0 and the updated user_score or com_score == MATCH_POINTS, go to OVER with match_winner set to the scorer. Otherwise go to IDLE.
- OVER: match_over=1, play ignored; exits only via new_match or reset.
- Latency:
  - Edges are N, N+1, N+2, N+3. play is sampled at edge N.
  - If com_ready is high at edge N+1, results, scores and commit are visible after edge N+2.
  - With com_ready low, each extra WAIT_COM cycle adds one.
- Result flags and com_loaded hold until the next accepted play or new_match.
- Strategies may use commit plus user_q for learning.

Test Plan:
- Reset then play user=00, com_ready=1 com=01 held → after 3 edges: uwin=1, user_score=1, round_count=1, commit single pulse, com_loaded=01.
- All 9 valid choice pairs in sequence → uwin/cwin/draw match the rule table; user_score=3, com_score=3, draw_count=3, round_count=9.
- Play with com_ready low for COM_TIMEOUT cycles → timeout pulse at cycle COM_TIMEOUT, scores unchanged, busy=0; next play accepted.
- Play with user_choice=11 → invalid pulse, busy stays 0. com_ready with com_choice=11 → not accepted until a valid choice arrives.
- MATCH_POINTS=3, computer wins 3 rounds → match_over=1, match_winner=0. Further play ignored. new_match → all counters 0, match_over=0.
- SCORE_W=2: 5 user wins → user_score saturates at 3. ROUND_W=2: 5 rounds → round_count=1.
- Assert reset, or pulse new_match, while in WAIT_COM → immediate IDLE, no commit, counters per rules.
